// File: rtl/xvec2_vscale_vstore_seq.sv
// Vector store sequencer: snapshots one 4-lane vector register group, then issues
// one word store per enabled lane at base + lane*stride, lowest lane first.
module xvec2_vscale_vstore_seq #(
   localparam int XPR_LEN        = 32,
   localparam int VEC_SIZE       = 4,
   localparam int VEC_XPR_LEN    = 128,
   localparam int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [REG_ADDR_WIDTH-1:0] cmd_vs,
   input  logic [XPR_LEN-1:0]        cmd_base,
   input  logic [XPR_LEN-1:0]        cmd_stride,
   input  logic [VEC_SIZE-1:0]       cmd_mask,
   output logic [REG_ADDR_WIDTH-1:0] vf_ra,
   input  logic [VEC_XPR_LEN-1:0]    vf_rd,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [XPR_LEN-1:0]        mem_req_addr,
   output logic [XPR_LEN-1:0]        mem_req_wdata,
   input  logic                      kill,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

   state_t                      state_q, state_d;
   logic [REG_ADDR_WIDTH-1:0]   grp_q;
   logic [XPR_LEN-1:0]          base_q;
   logic signed [XPR_LEN-1:0]   stride_q;
   logic [VEC_SIZE-1:0]         mask_q;
   logic [1:0]                  lane_q;
   logic [VEC_XPR_LEN-1:0]      snap_q;
   logic [2:0]                  first_pick, next_pick;
   logic [XPR_LEN-1:0]          lane_off;
   logic                        unused_vs;

   // Lowest enabled lane at or above 'from'; bit 2 set means no such lane.
   function automatic logic [2:0] pick_lane(input logic [VEC_SIZE-1:0] m, input logic [2:0] from);
      logic [2:0] r;
      r = 3'b100;
      for (int i = VEC_SIZE - 1; i >= 0; i--)
         if (m[i] && (3'(i) >= from)) r = {1'b0, 2'(i)};
      return r;
   endfunction

   assign unused_vs  = ^cmd_vs[1:0];
   assign first_pick = pick_lane(mask_q, 3'd0);
   assign next_pick  = pick_lane(mask_q, {1'b0, lane_q} + 3'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         grp_q    <= '0;
         base_q   <= '0;
         stride_q <= '0;
         mask_q   <= '0;
         lane_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && cmd_valid) begin
            grp_q    <= {cmd_vs[4:2], 2'b00};
            base_q   <= cmd_base;
            stride_q <= $signed(cmd_stride);
            mask_q   <= cmd_mask;
         end
         if (state_q == READ)
            lane_q <= first_pick[1:0];
         if (state_q == SEND && mem_req_ready && !next_pick[2])
            lane_q <= next_pick[1:0];
      end
   end

   // Snapshot isolates the in-flight command from later vector-file writes.
   always_ff @(posedge clk) begin
      if (state_q == READ) snap_q <= vf_rd;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cmd_valid) state_d = READ;
         READ: state_d = first_pick[2] ? DONE : SEND;
         SEND: if (mem_req_ready && next_pick[2]) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill && state_q != IDLE) state_d = IDLE;
   end

   always_comb begin
      cmd_ready     = (state_q == IDLE);
      busy          = (state_q != IDLE);
      mem_req_valid = (state_q == SEND);
      done          = (state_q == DONE);
   end

   // lane*stride for lane in 0..3 as a shift-add; wraps modulo 2^32.
   assign lane_off      = (lane_q[1] ? $unsigned(stride_q <<< 1) : '0) +
                          (lane_q[0] ? $unsigned(stride_q) : '0);
   assign mem_req_addr  = base_q + lane_off;
   assign mem_req_wdata = snap_q[{lane_q, 5'b00000} +: XPR_LEN];
   assign vf_ra         = grp_q;

endmodule

// File: tb/tb_xvec2_vscale_vstore_seq.sv
// Bench for xvec2_vscale_vstore_seq: queue-based store model, directed and random commands.
module tb_xvec2_vscale_vstore_seq;

   logic         clk = 1'b0;
   logic         reset, cmd_valid, cmd_ready, kill, busy, done;
   logic [4:0]   cmd_vs, vf_ra;
   logic [31:0]  cmd_base, cmd_stride, mem_req_addr, mem_req_wdata;
   logic [3:0]   cmd_mask;
   logic [127:0] vf_rd;
   logic         mem_req_valid, mem_req_ready;

   logic [127:0] vf [32];
   logic [63:0]  exp_q [$];
   int           checks = 0, fails = 0, done_cnt = 0;

   assign vf_rd = vf[vf_ra];

   xvec2_vscale_vstore_seq dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_vs(cmd_vs), .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_mask(cmd_mask),
      .vf_ra(vf_ra), .vf_rd(vf_rd), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .kill(kill), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_addr(input logic [31:0] base, input logic [31:0] stride, input int lane);
      return base + stride * 32'(lane);
   endfunction

   function automatic logic [31:0] lane_word(input logic [127:0] row, input int lane);
      return row[lane*32 +: 32];
   endfunction

   // Every store the DUT presents must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_req_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_store addr=%0h data=%0h required=none", mem_req_addr, mem_req_wdata);
         end else begin
            chk("store_addr", 64'(mem_req_addr), 64'(exp_q[0][63:32]));
            chk("store_data", 64'(mem_req_wdata), 64'(exp_q[0][31:0]));
            if (mem_req_ready === 1'b1) void'(exp_q.pop_front());
         end
      end
      if (done === 1'b1) begin
         chk("done_with_queue_empty", 64'(exp_q.size()), 64'(0));
         done_cnt++;
      end
   end

   task automatic run_cmd(input logic [4:0] vs, input logic [31:0] base, input logic [31:0] stride,
                          input logic [3:0] mask, input int stall0, input bit rnd,
                          input int kill_idx, input int rst_idx, input bit vf_wr, input bit kill_idle);
      int cyc, first_v, last_hs, hs, stall, done0;
      bit got_done;
      logic [4:0]   grp;
      logic [127:0] row;
      grp = {vs[4:2], 2'b00};
      row = vf[grp];
      for (int i = 0; i < 4; i++)
         if (mask[i]) exp_q.push_back({m_addr(base, stride, i), lane_word(row, i)});
      cmd_vs = vs; cmd_base = base; cmd_stride = stride; cmd_mask = mask;
      cmd_valid = 1'b1; kill = kill_idle; mem_req_ready = 1'b0;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      done0 = done_cnt;
      tick;
      cmd_valid = 1'b0; kill = 1'b0;
      cyc = 1; first_v = -1; last_hs = -1; hs = 0; stall = 0; got_done = 1'b0;
      chk("read_state", 64'({busy, cmd_ready, mem_req_valid}), 64'(3'b100));
      chk("vf_ra_group", 64'(vf_ra), 64'(grp));
      for (int t = 0; t < 60; t++) begin
         if (done === 1'b1) begin
            got_done = 1'b1;
            chk("done_latency", 64'(cyc), (mask == 4'd0) ? 64'(2) : 64'(last_hs + 1));
            break;
         end
         if (vf_wr && cyc == 2) vf[grp] = {$urandom, $urandom, $urandom, $urandom};
         mem_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mem_req_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc;
            if (hs == 0 && stall < stall0) begin
               mem_req_ready = 1'b0;
               stall++;
            end
            if (hs == kill_idx) begin
               kill = 1'b1;
               if (!rnd) mem_req_ready = 1'b0;
               tick;
               kill = 1'b0; mem_req_ready = 1'b0;
               chk("kill_to_idle", 64'({cmd_ready, busy, mem_req_valid, done}), 64'(4'b1000));
               exp_q.delete();
               tick;
               chk("kill_no_done", 64'(done_cnt - done0), 64'(0));
               return;
            end
            if (hs == rst_idx) begin
               reset = 1'b1;
               tick;
               reset = 1'b0; mem_req_ready = 1'b0;
               chk("reset_mid_send", 64'({mem_req_valid, cmd_ready, busy, done}), 64'(4'b0100));
               chk("reset_vf_ra", 64'(vf_ra), 64'(0));
               exp_q.delete();
               tick;
               chk("reset_no_done", 64'(done_cnt - done0), 64'(0));
               return;
            end
            if (mem_req_ready) begin
               hs++;
               last_hs = cyc;
            end
         end
         tick;
         cyc++;
      end
      mem_req_ready = 1'b0;
      if (!got_done) begin
         checks++;
         fails++;
         $display("FAIL done_timeout actual=none required=done");
      end
      chk("first_valid_latency", 64'(first_v), (mask == 4'd0) ? 64'(-1) : 64'(2));
      chk("store_count", 64'(hs), 64'($countones(mask)));
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      if (!rnd && stall0 == 0 && mask != 4'd0)
         chk("back_to_back", 64'(last_hs), 64'(1 + $countones(mask)));
      exp_q.delete();
      tick;
      chk("after_done_idle", 64'({cmd_ready, busy, done}), 64'(3'b100));
      chk("single_done", 64'(done_cnt - done0), 64'(1));
   endtask

   initial begin
      int ki, ri;
      logic [3:0] m;
      for (int i = 0; i < 32; i++) vf[i] = {$urandom, $urandom, $urandom, $urandom};
      vf[0] = '0;
      vf[8] = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
      vf[4] = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
      reset = 1'b1; cmd_valid = 1'b0; kill = 1'b0; mem_req_ready = 1'b0;
      cmd_vs = '0; cmd_base = '0; cmd_stride = '0; cmd_mask = '0;
      repeat (3) tick;
      chk("reset_state", 64'({cmd_ready, busy, done, mem_req_valid}), 64'(4'b1000));
      chk("reset_vf_ra", 64'(vf_ra), 64'(0));
      reset = 1'b0;
      tick;

      chk("pin_addr_lane3", 64'(m_addr(32'h1000, 32'd4, 3)), 64'(32'h100C));
      chk("pin_addr_neg1", 64'(m_addr(32'h2000, -32'sd8, 1)), 64'(32'h1FF8));
      chk("pin_addr_neg3", 64'(m_addr(32'h2000, -32'sd8, 3)), 64'(32'h1FE8));
      chk("pin_addr_wrap", 64'(m_addr(32'hFFFFFFFC, 32'd8, 1)), 64'(32'h4));
      chk("pin_lane_word", 64'(lane_word(vf[8], 2)), 64'(32'hC2C2C2C2));

      kill = 1'b1;
      tick;
      kill = 1'b0;
      chk("kill_in_idle_ignored", 64'({cmd_ready, busy}), 64'(2'b10));

      run_cmd(5'd8, 32'h1000, 32'd4, 4'b1111, 0, 1'b0, -1, -1, 1'b0, 1'b0);
      run_cmd(5'd5, 32'h2000, -32'sd8, 4'b1010, 0, 1'b0, -1, -1, 1'b0, 1'b0);
      run_cmd(5'd9, 32'h3000, 32'd4, 4'b0000, 0, 1'b0, -1, -1, 1'b0, 1'b0);
      run_cmd(5'd12, 32'hFFFFFFFC, 32'd8, 4'b0011, 0, 1'b0, -1, -1, 1'b0, 1'b0);
      run_cmd(5'd8, 32'h1000, 32'd4, 4'b1111, 3, 1'b0, -1, -1, 1'b1, 1'b0);
      run_cmd(5'd2, 32'h4000, 32'd16, 4'b0101, 0, 1'b0, -1, -1, 1'b0, 1'b1);
      run_cmd(5'd16, 32'h5000, 32'd4, 4'b1111, 0, 1'b0, 2, -1, 1'b0, 1'b0);
      run_cmd(5'd20, 32'h6000, 32'd4, 4'b1111, 0, 1'b0, -1, 1, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         m  = 4'($urandom_range(0, 15));
         ki = -1;
         ri = -1;
         if (m != 4'd0 && $urandom_range(0, 5) == 0) ki = $urandom_range(0, $countones(m) - 1);
         else if (m != 4'd0 && $urandom_range(0, 9) == 0) ri = $urandom_range(0, $countones(m) - 1);
         run_cmd(5'($urandom_range(0, 31)), $urandom, $urandom, m, $urandom_range(0, 2), 1'b1,
                 ki, ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
